// File: rtl/scan_resp_pkg.sv
// Shared types and constants for the scan responder.
package scan_resp_pkg;

  // Responder FSM. StMemResp is the memory response cycle; requests there are
  // still dropped because the transaction has not fully retired.
  typedef enum logic [1:0] {
    StIdle,
    StMemWait,
    StMemResp
  } state_e;

  localparam logic [14:0] STATUS_IDX   = 15'h7FFF;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // STATUS field offsets
  localparam int unsigned STATUS_TO_BIT  = 0;
  localparam int unsigned STATUS_OV_BIT  = 1;
  localparam int unsigned STATUS_CNT_LSB = 8;

  function automatic logic [31:0] pack_status(input logic [7:0] ovr_cnt,
                                              input logic       err_ov,
                                              input logic       err_to);
    logic [31:0] s;
    s = '0;
    s[STATUS_CNT_LSB +: 8] = ovr_cnt;
    s[STATUS_OV_BIT]       = err_ov;
    s[STATUS_TO_BIT]       = err_to;
    return s;
  endfunction

endpackage

// File: rtl/scan_cfg_regbank.sv
// Local configuration register bank: write decode, read mux, flattened view.
// Indices at or above NREG are unmapped: writes ignored, reads return 0.
module scan_cfg_regbank #(
  parameter int unsigned NREG = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [14:0]       idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NREG*32-1:0] cfg_regs
);

  logic [31:0] regs_q [NREG];

  // Register storage; only a matching in-range index is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (idx == 15'(i)) regs_q[i] <= wdata;
      end
    end
  end

  // Read mux; unmatched index falls through to 0.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == 15'(i)) rdata = regs_q[i];
    end
  end

  // Flatten the array onto the cfg_regs bus.
  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NREG; i++) cfg_regs[32*i +: 32] = regs_q[i];
  end

endmodule

// File: rtl/scan_mem_reg_resp.sv
// Responder end of the scan pulse interface. Register requests complete in one
// cycle; memory requests run a req/ack handshake bounded by TIMEOUT cycles.
module scan_mem_reg_resp
  import scan_resp_pkg::*;
#(
  parameter int unsigned NREG    = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned MEM_AW  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_wen,
  input  logic               scan_ren,
  input  logic [15:0]        scan_addr,
  input  logic [31:0]        scan_wdata,
  output logic [31:0]        scan_rdata,
  output logic               scan_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack,
  output logic [NREG*32-1:0] cfg_regs,
  output logic               err_timeout,
  output logic               err_overrun
);

  // Counter value in the last MEM_WAIT cycle before timeout.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;
  logic [7:0]        ovr_cnt_q, ovr_cnt_d;

  logic        req;
  logic        is_mem;
  logic [14:0] idx;
  logic        status_hit;
  logic        reg_we;
  logic [31:0] bank_rdata;
  logic [31:0] status;

  assign req        = scan_wen | scan_ren;
  assign is_mem     = scan_addr[15];
  assign idx        = scan_addr[14:0];
  assign status_hit = (idx == STATUS_IDX);
  // scan_wen wins when both pulses are present.
  assign reg_we     = (state_q == StIdle) && scan_wen && !is_mem;
  assign status     = pack_status(ovr_cnt_q, err_ov_q, err_to_q);

  scan_cfg_regbank #(
    .NREG(NREG)
  ) u_regbank (
    .clk     (clk),
    .rst     (rst),
    .we      (reg_we),
    .idx     (idx),
    .wdata   (scan_wdata),
    .rdata   (bank_rdata),
    .cfg_regs(cfg_regs)
  );

  // Next-state, response and error/status logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    err_to_d    = err_to_q;
    err_ov_d    = err_ov_q;
    ovr_cnt_d   = ovr_cnt_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (is_mem) begin
            mem_we_d    = scan_wen;
            mem_addr_d  = scan_addr[MEM_AW-1:0];
            mem_wdata_d = scan_wdata;
            cnt_d       = '0;
            state_d     = StMemWait;
          end else begin
            ready_d = 1'b1;
            if (scan_wen) begin
              rdata_d = '0;
              if (status_hit) begin
                if (scan_wdata[STATUS_TO_BIT]) err_to_d = 1'b0;
                if (scan_wdata[STATUS_OV_BIT]) begin
                  err_ov_d  = 1'b0;
                  ovr_cnt_d = '0;
                end
              end
            end else begin
              rdata_d = status_hit ? status : bank_rdata;
            end
          end
        end
      end
      StMemWait: begin
        // Ack takes priority over a simultaneous timeout.
        if (mem_ack) begin
          ready_d = 1'b1;
          rdata_d = mem_we_q ? '0 : mem_rdata;
          state_d = StMemResp;
        end else if (cnt_q == CntLast) begin
          ready_d  = 1'b1;
          rdata_d  = TIMEOUT_DATA;
          err_to_d = 1'b1;
          state_d  = StMemResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StMemResp: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Requests outside IDLE are dropped and counted.
    if (req && (state_q != StIdle)) begin
      err_ov_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      err_to_q    <= err_to_d;
      err_ov_q    <= err_ov_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign mem_req     = (state_q == StMemWait);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign scan_ready  = ready_q;
  assign scan_rdata  = rdata_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_scan_mem_reg_resp.sv
// Bench for scan_mem_reg_resp: scenario tasks push expected responses into a
// queue; a monitor running alongside pops one per scan_ready pulse.
module tb_scan_mem_reg_resp;

  localparam int unsigned NREG    = 8;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned MEM_AW  = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               scan_wen, scan_ren;
  logic [15:0]        scan_addr;
  logic [31:0]        scan_wdata;
  logic [31:0]        scan_rdata;
  logic               scan_ready;
  logic               mem_req, mem_we;
  logic [MEM_AW-1:0]  mem_addr;
  logic [31:0]        mem_wdata, mem_rdata;
  logic               mem_ack;
  logic [NREG*32-1:0] cfg_regs;
  logic               err_timeout, err_overrun;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  bit          done  = 1'b0;

  scan_mem_reg_resp #(
    .NREG   (NREG),
    .TIMEOUT(TIMEOUT),
    .MEM_AW (MEM_AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_wen   (scan_wen),
    .scan_ren   (scan_ren),
    .scan_addr  (scan_addr),
    .scan_wdata (scan_wdata),
    .scan_rdata (scan_rdata),
    .scan_ready (scan_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .cfg_regs   (cfg_regs),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic wen, input logic ren, input logic [15:0] addr,
                       input logic [31:0] wdata);
    scan_wen   = wen;
    scan_ren   = ren;
    scan_addr  = addr;
    scan_wdata = wdata;
  endtask

  task automatic quiet();
    scan_wen = 1'b0;
    scan_ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    tests++;
    if ({scan_ready, mem_req, mem_we, err_timeout, err_overrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b required 00000",
               {scan_ready, mem_req, mem_we, err_timeout, err_overrun});
    end
    tests++;
    if (cfg_regs !== '0 || scan_rdata !== '0) begin
      fails++;
      $display("FAIL reset_data: got cfg=%h rdata=%h required 0", cfg_regs, scan_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reg_write_read();
    drive(1'b1, 1'b0, 16'h0002, 32'h1234_5678); exp_q.push_back(32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0002, 32'h0); exp_q.push_back(32'h1234_5678);
    tests++;
    if (scan_ready !== 1'b1 || cfg_regs[95:64] !== 32'h1234_5678) begin
      fails++;
      $display("FAIL reg_write: got ready=%b reg2=%h required 1/12345678",
               scan_ready, cfg_regs[95:64]);
    end
    @(negedge clk);
    quiet();
    tests++;
    if (scan_ready !== 1'b1) begin
      fails++;
      $display("FAIL reg_read_ready: got %b required 1", scan_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'(i), 32'hA000_0000 + 32'(i));
      exp_q.push_back(32'h0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'(i), 32'h0);
      exp_q.push_back(32'hA000_0000 + 32'(i));
      @(negedge clk);
      tests++;
      if (scan_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", i, scan_ready);
      end
    end
    quiet();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    drive(1'b0, 1'b1, 16'h8010, 32'h0); exp_q.push_back(32'hCAFE_0001);
    @(negedge clk);
    quiet();
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 15'h0010 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL mem_read_port: got req=%b addr=%h we=%b required 1/0010/0",
               mem_req, mem_addr, mem_we);
    end
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    tests++;
    if (mem_req !== 1'b0 || scan_ready !== 1'b1) begin
      fails++;
      $display("FAIL mem_read_done: got req=%b ready=%b required 0/1", mem_req, scan_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_mem_write();
    drive(1'b1, 1'b0, 16'h8123, 32'h0000_A5A5); exp_q.push_back(32'h0);
    @(negedge clk);
    quiet();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 15'h0123 || mem_wdata !== 32'h0000_A5A5) begin
      fails++;
      $display("FAIL mem_write_port: got we=%b addr=%h wdata=%h required 1/0123/0000a5a5",
               mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    tests++;
    if (scan_ready !== 1'b1) begin
      fails++;
      $display("FAIL mem_write_latency: got ready=%b required 1", scan_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    drive(1'b0, 1'b1, 16'h8001, 32'h0); exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    quiet();
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    tests++;
    if (n != int'(TIMEOUT)) begin
      fails++;
      $display("FAIL timeout_len: got %0d req cycles required %0d", n, TIMEOUT);
    end
    tests++;
    if (scan_ready !== 1'b1 || err_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout_resp: got ready=%b err=%b required 1/1", scan_ready, err_timeout);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h7FFF, 32'h0); exp_q.push_back(32'h0000_0001);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h7FFF, 32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    quiet();
    @(negedge clk);
    tests++;
    if (err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b required 0", err_timeout);
    end
  endtask

  task automatic test_ack_at_timeout();
    drive(1'b0, 1'b1, 16'h8002, 32'h0); exp_q.push_back(32'h0000_0077);
    @(negedge clk);
    quiet();
    repeat (TIMEOUT - 1) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    tests++;
    if (scan_ready !== 1'b1 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL ack_at_timeout: got ready=%b err=%b required 1/0", scan_ready, err_timeout);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    drive(1'b0, 1'b1, 16'h8003, 32'h0); exp_q.push_back(32'h0BAD_0003);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0002, 32'h0);
    @(negedge clk);
    quiet();
    tests++;
    if (err_overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_flag: got %b required 1", err_overrun);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0003;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b1, 1'b0, 16'h0003, 32'h5555_5555);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h7FFF, 32'h0); exp_q.push_back(32'h0000_0202);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h7FFF, 32'h3); exp_q.push_back(32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h7FFF, 32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    quiet();
    tests++;
    if (err_overrun !== 1'b0 || cfg_regs[127:96] !== 32'hA000_0003) begin
      fails++;
      $display("FAIL overrun_clear: got ovr=%b reg3=%h required 0/a0000003",
               err_overrun, cfg_regs[127:96]);
    end
    @(negedge clk);
  endtask

  task automatic test_both_and_unmapped();
    drive(1'b1, 1'b1, 16'h0000, 32'h0000_F00D); exp_q.push_back(32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0050, 32'hFFFF_FFFF); exp_q.push_back(32'h0);
    tests++;
    if (cfg_regs[31:0] !== 32'h0000_F00D) begin
      fails++;
      $display("FAIL both_pulses: got reg0=%h required 0000f00d", cfg_regs[31:0]);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0050, 32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0008, 32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    quiet();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL ack_in_idle: got req=%b required 0", mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 16'h8004, 32'h0);
    @(negedge clk);
    quiet();
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got req=%b required 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b0 || scan_ready !== 1'b0 || cfg_regs !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: got req=%b ready=%b cfg=%h required 0/0/0",
               mem_req, scan_ready, cfg_regs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || scan_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_after: got req=%b rdata=%h required 0/0", mem_req, scan_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    fork
      begin
        test_reset();
        test_reg_write_read();
        test_back_to_back();
        test_mem_read();
        test_mem_write();
        test_timeout();
        test_ack_at_timeout();
        test_overrun();
        test_both_and_unmapped();
        test_reset_mid();
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
          fails++;
          $display("FAIL missing_resp: got %0d outstanding required 0", exp_q.size());
        end
        done = 1'b1;
      end
      begin
        // Response monitor: each scan_ready pulse consumes one expectation.
        while (!done) begin
          @(negedge clk);
          if (scan_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL extra_resp: got ready with rdata=%h required no response",
                       scan_rdata);
            end else begin
              logic [31:0] e;
              e = exp_q.pop_front();
              if (scan_rdata !== e) begin
                fails++;
                $display("FAIL resp_data: got %h required %h", scan_rdata, e);
              end
            end
          end
        end
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_mem_reg_resp.md
# scan_mem_reg_resp

Responder end of the scan read/write pulse interface. It accepts single-cycle `scan_wen`/`scan_ren` request pulses from the scan controller and returns one `scan_ready` pulse with `scan_rdata` for every accepted request. Requests go either to a local configuration register bank or to a downstream memory port. The memory port uses a req/ack handshake with a timeout. It sits between the scan controller and the memory/register fabric of the group.

## Interface
- `NREG`, 8 — number of 32-bit config registers; 1..16.
- `TIMEOUT`, 255 — max cycles waiting for `mem_ack`; 2..65535.
- `MEM_AW`, 15 — memory port address width; ≤15.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `scan_wen` in 1 — write request pulse, one cycle.
- `scan_ren` in 1 — read request pulse, one cycle.
- `scan_addr` in 16 — request address, valid in the pulse cycle.
- `scan_wdata` in 32 — write data, valid in the pulse cycle.
- `scan_rdata` out 32 — response data; valid while `scan_ready` is high, held until the next response.
- `scan_ready` out 1 — one-cycle response pulse.
- `mem_req` out 1 — memory request; held high until ack or timeout.
- `mem_we` out 1 — memory write enable; stable while `mem_req` is high.
- `mem_addr` out MEM_AW — memory address.
- `mem_wdata` out 32 — memory write data.
- `mem_rdata` in 32 — memory read data; valid with `mem_ack`.
- `mem_ack` in 1 — memory completion, one cycle.
- `cfg_regs` out NREG*32 — flattened config registers; register i is bits [32i+31:32i].
- `err_timeout` out 1 — sticky memory-timeout flag.
- `err_overrun` out 1 — sticky dropped-request flag.

## Operation
- Request: `scan_wen | scan_ren` sampled high. If both are high, it is a write and the read is ignored.
- Address map, for `scan_addr[15]` = 0:
  - index `scan_addr[14:0]` < NREG → config register.
  - index 15'h7FFF → STATUS (read-only except clear bits).
  - other indices are unmapped: writes ignored, reads return 0.
- Address map, for `scan_addr[15]` = 1: memory; `mem_addr` = `scan_addr[MEM_AW-1:0]`.
- STATUS = {16'h0, `ovr_cnt`[7:0], 6'b0, `err_overrun`, `err_timeout`}.
- Writing STATUS: bit0 = 1 clears `err_timeout`; bit1 = 1 clears `err_overrun` and `ovr_cnt`.
- Write responses return `scan_rdata` = 0.
- FSM states:
  - IDLE. On a register request: write or read takes effect at that edge, response next cycle, stay in IDLE. On a memory request: latch `we`/addr/wdata, go to MEM_WAIT.
  - MEM_WAIT. `mem_req` = 1, timeout counter increments each cycle. On `mem_ack`: response with `mem_rdata` (0 for writes), go to IDLE. When the counter reaches TIMEOUT with no ack: response with 32'hDEAD_BEEF, set `err_timeout`, go to IDLE.
- Any request arriving in MEM_WAIT is dropped: no response, `err_overrun` = 1, `ovr_cnt` increments and saturates at 255.
- `mem_ack` seen in IDLE is ignored.
- Reset values: every output 0, `cfg_regs` 0, `ovr_cnt` 0, state IDLE, counter 0.

## Timing
- Register access: request at edge N → `scan_ready` = 1 for cycle N+1. A write is visible on `cfg_regs` from cycle N+1.
- Back-to-back register requests, one per cycle, are all accepted; one `scan_ready` pulse follows each.
- Memory access:
  - Request at edge N → `mem_req` high from cycle N+1.
  - `mem_ack` sampled at edge M → `mem_req` low and `scan_ready` high in cycle M+1.
  - Best-case memory latency is 2 cycles, request to `scan_ready`.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `scan_ready` follows in the next cycle.
- If `mem_ack` arrives in the same cycle the timeout expires, the ack wins and no error is raised.
- A request in the `scan_ready` cycle of a memory response is still dropped, because the FSM has not yet returned to IDLE.
- Reset asserted mid-transaction: `mem_req` and `scan_ready` drop asynchronously and no response is generated for the in-flight request.

## Structure
- Package `scan_resp_pkg` holds:
  - FSM state enum.
  - STATUS_IDX = 15'h7FFF.
  - TIMEOUT_DATA = 32'hDEAD_BEEF.
  - STATUS field offsets.
- Sub-module `scan_cfg_regbank`: NREG registers, write decode, read mux, unmapped handling. The top level holds the FSM, memory port, timeout counter and error/status logic.

## Test plan
- Write 32'h1234_5678 to addr 0x0002 → `scan_ready` the next cycle with `scan_rdata` = 0; `cfg_regs`[95:64] = 32'h1234_5678. Read 0x0002 → `scan_rdata` = 32'h1234_5678.
- Read 0x8010 with memory acking 3 cycles after `mem_req` and `mem_rdata` = 32'hCAFE_0001 → `mem_addr` = 15'h0010, `mem_we` = 0, `scan_rdata` = 32'hCAFE_0001, `scan_ready` 1 cycle after ack.
- Memory never acks, TIMEOUT = 4 → `mem_req` high for 4 cycles, then `scan_rdata` = 32'hDEAD_BEEF and `err_timeout` = 1. A following STATUS read returns bit0 = 1.
- Second request during MEM_WAIT → no extra `scan_ready`, `err_overrun` = 1. STATUS read gives `ovr_cnt` = 1. Writing STATUS with 32'h3 clears both flags and the count.
- `scan_wen` and `scan_ren` both high to addr 0x0000 → write performed, `scan_rdata` = 0. Read of unmapped 0x0050 → 0 with `scan_ready`.
- Assert `rst` while `mem_req` is high → `mem_req` low immediately, no `scan_ready`, `cfg_regs` = 0. A later `mem_ack` is ignored.
